// File: rtl/dcache_2way_top_if.sv
// CPU data port and line-wide memory port of the 2-way data cache, grouped as one bundle.
// slave = cache side, master = CPU/memory environment side.
interface dcache_2way_top_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [31:0]       p1_data_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic              p1_MemRead_i;
  logic              p1_MemWrite_i;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;

  modport slave (
    input  p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );
  modport master (
    output p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back/write-allocate data cache with per-set LRU.
// Optional access/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_2way_top #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_2way_top_if.slave   bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]        acc_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MISS     = 3'd1;
  localparam logic [2:0] S_WB       = 3'd2;
  localparam logic [2:0] S_RM       = 3'd3;
  localparam logic [2:0] S_RMOK     = 3'd4;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  p1_tag;
  logic [WSEL_W-1:0] wsel;
  logic              unused_addr_lsb;

  assign idx             = bus.p1_addr_i[OFF_W +: IDX_W];
  assign p1_tag          = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel            = bus.p1_addr_i[2 +: WSEL_W];
  assign unused_addr_lsb = ^bus.p1_addr_i[1:0];

  logic [2:0]            state_q, state_d;
  logic                  victim_q, victim_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [SETS-1:0][1:0]  valid_q, valid_d;
  logic [SETS-1:0][1:0]  dirty_q, dirty_d;
  logic [SETS-1:0]       lru_q, lru_d;

  logic [TAG_W-1:0]      tag_q  [SETS][2];
  logic [LINE_W-1:0]     line_q [SETS][2];

  logic [1:0] hit_w;
  logic       req, hit, hit_way, idle_hit, store_we, refill_we;

  assign hit_w[0]  = valid_q[idx][0] && (tag_q[idx][0] == p1_tag);
  assign hit_w[1]  = valid_q[idx][1] && (tag_q[idx][1] == p1_tag);
  assign req       = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign hit       = |hit_w;
  assign hit_way   = hit_w[1];
  assign idle_hit  = (state_q == S_IDLE) && req && hit;
  assign store_we  = idle_hit && bus.p1_MemWrite_i;
  assign refill_we = (state_q == S_RM) && mem_en_q && bus.mem_ack_i;

  assign bus.p1_data_o    = (req && hit) ? line_q[idx][hit_way][{wsel, 5'd0} +: 32] : 32'd0;
  assign bus.p1_stall_o   = (req && !hit) || (state_q != S_IDLE);
  assign bus.mem_enable_o = mem_en_q;
  assign bus.mem_write_o  = mem_wr_q;
  assign bus.mem_addr_o   = {((state_q == S_WB) ? tag_q[idx][victim_q] : p1_tag), idx, {OFF_W{1'b0}}};
  assign bus.mem_data_o   = line_q[idx][victim_q];

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    mem_en_d = mem_en_q;
    mem_wr_d = mem_wr_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    lru_d    = lru_q;
    case (state_q)
      S_IDLE: begin
        if (idle_hit) begin
          lru_d[idx] = ~hit_way;
          if (bus.p1_MemWrite_i) dirty_d[idx][hit_way] = 1'b1;
        end else if (req) begin
          state_d = S_MISS;
          if (!valid_q[idx][0])      victim_d = 1'b0;
          else if (!valid_q[idx][1]) victim_d = 1'b1;
          else                       victim_d = lru_q[idx];
        end
      end
      S_MISS: begin
        mem_en_d = 1'b1;
        mem_wr_d = valid_q[idx][victim_q] & dirty_q[idx][victim_q];
        state_d  = mem_wr_d ? S_WB : S_RM;
      end
      S_WB: begin
        if (bus.mem_ack_i) begin
          mem_en_d = 1'b0;
          mem_wr_d = 1'b0;
          state_d  = S_RM;
        end
      end
      S_RM: begin
        // Entered from WRITEBACK with the request dropped: re-raise it for the refill.
        if (!mem_en_q) begin
          mem_en_d = 1'b1;
        end else if (bus.mem_ack_i) begin
          mem_en_d                  = 1'b0;
          valid_d[idx][victim_q]    = 1'b1;
          dirty_d[idx][victim_q]    = 1'b0;
          state_d                   = S_RMOK;
        end
      end
      S_RMOK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      victim_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      lru_q    <= lru_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (refill_we) begin
      line_q[idx][victim_q] <= bus.mem_data_i;
      tag_q[idx][victim_q]  <= p1_tag;
    end else if (store_we) begin
      line_q[idx][hit_way][{wsel, 5'd0} +: 32] <= bus.p1_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] acc_q, acc_d, miss_q, miss_d;

  always_comb begin
    acc_d  = sat_inc(acc_q, idle_hit);
    miss_d = sat_inc(miss_q, (state_q == S_IDLE) && (state_d == S_MISS));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q  <= '0;
      miss_q <= '0;
    end else begin
      acc_q  <= acc_d;
      miss_q <= miss_d;
    end
  end

  assign acc_cnt_o  = acc_q;
  assign miss_cnt_o = miss_q;
`endif
endmodule

// File: tb/tb_dcache_2way_top.sv
// Directed bench for dcache_2way_top: refill, store hit, second way, dirty eviction, reset mid-refill.
// Counter checks are compiled in when DCACHE_STATS_EN is defined.
module tb_dcache_2way_top;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_2way_top_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] acc_cnt, miss_cnt;
`endif

  dcache_2way_top #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .acc_cnt_o  (acc_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [LINE_W-1:0] mem [logic [31:0]];
  logic [31:0]       rdata;
  int                stalls, n_wb, n_rd;
  logic [31:0]       wb_addr, rd_addr;
  logic [LINE_W-1:0] wb_data;

  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    bus.p1_addr_i     = addr;
    bus.p1_data_i     = wd;
    bus.p1_MemRead_i  = ~wr;
    bus.p1_MemWrite_i = wr;
    stalls = 0; n_wb = 0; n_rd = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (!bus.p1_stall_o) break;
      stalls++;
      if (bus.mem_enable_o) begin
        bus.mem_ack_i = 1'b1;
        if (bus.mem_write_o) begin
          n_wb++;
          wb_addr = bus.mem_addr_o;
          wb_data = bus.mem_data_o;
          mem[bus.mem_addr_o] = bus.mem_data_o;
        end else begin
          n_rd++;
          rd_addr = bus.mem_addr_o;
          bus.mem_data_i = mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o] : '0;
        end
      end
      @(posedge clk);
      #1 bus.mem_ack_i = 1'b0;
    end
    n_cmp++;
    if (bus.p1_stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL access_timeout addr=%h stall=%b required 0", addr, bus.p1_stall_o);
    end
    rdata = bus.p1_data_o;
    @(posedge clk);
    #1;
    bus.p1_MemRead_i  = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.p1_addr_i = 32'h44; bus.p1_data_i = '0;
    bus.p1_MemRead_i = 1'b1; bus.p1_MemWrite_i = 1'b0;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.p1_stall_o !== 1'b1) begin n_err++; $display("FAIL rst_stall got %b exp 1", bus.p1_stall_o); end
    n_cmp++; if (bus.p1_data_o !== 32'd0) begin n_err++; $display("FAIL rst_data got %h exp 0", bus.p1_data_o); end
    n_cmp++; if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mem_ctl got en=%b wr=%b exp 0/0", bus.mem_enable_o, bus.mem_write_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h40) begin n_err++; $display("FAIL rst_mem_addr got %h exp 00000040", bus.mem_addr_o); end
`ifdef DCACHE_STATS_EN
    n_cmp++; if (acc_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_err++; $display("FAIL rst_counters got acc=%0d miss=%0d exp 0/0", acc_cnt, miss_cnt); end
`endif
    bus.p1_MemRead_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean_miss();
    access(32'h40, 1'b0, 32'h0);
    n_cmp++; if (stalls != 4) begin n_err++; $display("FAIL clean_miss_stalls got %0d exp 4", stalls); end
    n_cmp++; if (n_rd != 1 || n_wb != 0) begin n_err++; $display("FAIL clean_miss_txns got rd=%0d wb=%0d exp 1/0", n_rd, n_wb); end
    n_cmp++; if (rd_addr !== 32'h40) begin n_err++; $display("FAIL clean_miss_addr got %h exp 00000040", rd_addr); end
    n_cmp++; if (rdata !== 32'h1111_1111) begin n_err++; $display("FAIL clean_miss_data got %h exp 11111111", rdata); end
  endtask

  task automatic test_write_hit();
    access(32'h44, 1'b1, 32'hDEAD_BEEF);
    n_cmp++; if (stalls != 0) begin n_err++; $display("FAIL store_hit_stalls got %0d exp 0", stalls); end
    access(32'h44, 1'b0, 32'h0);
    n_cmp++; if (rdata !== 32'hDEAD_BEEF || stalls != 0) begin
      n_err++; $display("FAIL load_after_store got %h/%0d exp deadbeef/0", rdata, stalls); end
    access(32'h40, 1'b0, 32'h0);
    n_cmp++; if (rdata !== 32'h1111_1111) begin n_err++; $display("FAIL word0_kept got %h exp 11111111", rdata); end
    access(32'h48, 1'b0, 32'h0);
    n_cmp++; if (rdata !== 32'h3333_3333) begin n_err++; $display("FAIL word2_kept got %h exp 33333333", rdata); end
  endtask

  task automatic test_second_way();
    access(32'h440, 1'b0, 32'h0);
    n_cmp++; if (stalls != 4 || n_wb != 0) begin n_err++; $display("FAIL way1_refill got stalls=%0d wb=%0d exp 4/0", stalls, n_wb); end
    n_cmp++; if (rdata !== 32'hB0B0_0000) begin n_err++; $display("FAIL way1_data got %h exp b0b00000", rdata); end
    access(32'h44, 1'b0, 32'h0);
    n_cmp++; if (rdata !== 32'hDEAD_BEEF || stalls != 0) begin
      n_err++; $display("FAIL way0_still_hits got %h/%0d exp deadbeef/0", rdata, stalls); end
  endtask

  task automatic test_dirty_evict();
    access(32'h440, 1'b0, 32'h0);
    access(32'h840, 1'b0, 32'h0);
    n_cmp++; if (stalls != 6) begin n_err++; $display("FAIL dirty_miss_stalls got %0d exp 6", stalls); end
    n_cmp++; if (n_wb != 1 || wb_addr !== 32'h40) begin n_err++; $display("FAIL wb_addr got n=%0d addr=%h exp 1/00000040", n_wb, wb_addr); end
    n_cmp++; if (wb_data[63:32] !== 32'hDEAD_BEEF || wb_data[31:0] !== 32'h1111_1111) begin
      n_err++; $display("FAIL wb_data got %h_%h exp deadbeef_11111111", wb_data[63:32], wb_data[31:0]); end
    n_cmp++; if (n_rd != 1 || rd_addr !== 32'h840) begin n_err++; $display("FAIL evict_rd_addr got n=%0d addr=%h exp 1/00000840", n_rd, rd_addr); end
    n_cmp++; if (rdata !== 32'hC0C0_0000) begin n_err++; $display("FAIL evict_data got %h exp c0c00000", rdata); end
    access(32'h440, 1'b0, 32'h0);
    n_cmp++; if (rdata !== 32'hB0B0_0000 || stalls != 0) begin
      n_err++; $display("FAIL way1_survives got %h/%0d exp b0b00000/0", rdata, stalls); end
    access(32'h44, 1'b0, 32'h0);
    n_cmp++; if (rdata !== 32'hDEAD_BEEF || stalls != 4 || n_wb != 0) begin
      n_err++; $display("FAIL refetch_written_back got %h/%0d/%0d exp deadbeef/4/0", rdata, stalls, n_wb); end
  endtask

  task automatic test_ack_ignored();
    @(negedge clk);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = '1;
    @(posedge clk);
    #1 bus.mem_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.p1_stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin
      n_err++; $display("FAIL stray_ack got stall=%b en=%b exp 0/0", bus.p1_stall_o, bus.mem_enable_o); end
    @(posedge clk);
    #1;
    access(32'h44, 1'b0, 32'h0);
    n_cmp++; if (rdata !== 32'hDEAD_BEEF || stalls != 0) begin
      n_err++; $display("FAIL after_stray_ack got %h/%0d exp deadbeef/0", rdata, stalls); end
`ifdef DCACHE_STATS_EN
    n_cmp++; if (acc_cnt !== 32'd12 || miss_cnt !== 32'd4) begin
      n_err++; $display("FAIL stats_counts got acc=%0d miss=%0d exp 12/4", acc_cnt, miss_cnt); end
`endif
  endtask

  task automatic test_reset_mid_refill();
    logic found;
    found = 1'b0;
    bus.p1_addr_i = 32'h1040; bus.p1_MemRead_i = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.mem_enable_o && !bus.mem_write_o) begin found = 1'b1; break; end
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL reach_readmiss got %b exp 1", found); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_mem got en=%b wr=%b exp 0/0", bus.mem_enable_o, bus.mem_write_o); end
    n_cmp++; if (bus.p1_stall_o !== 1'b1 || bus.p1_data_o !== 32'd0) begin
      n_err++; $display("FAIL mid_rst_cpu got stall=%b data=%h exp 1/0", bus.p1_stall_o, bus.p1_data_o); end
`ifdef DCACHE_STATS_EN
    n_cmp++; if (acc_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_err++; $display("FAIL mid_rst_counters got acc=%0d miss=%0d exp 0/0", acc_cnt, miss_cnt); end
`endif
    bus.p1_MemRead_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(32'h440, 1'b0, 32'h0);
    n_cmp++; if (stalls != 4 || rdata !== 32'hB0B0_0000) begin
      n_err++; $display("FAIL post_rst_miss got %0d/%h exp 4/b0b00000", stalls, rdata); end
    access(32'h44, 1'b0, 32'h0);
    n_cmp++; if (stalls != 4 || rdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL post_rst_way1 got %0d/%h exp 4/deadbeef", stalls, rdata); end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats_saturate();
    n_cmp++; if (acc_cnt !== 32'd2 || miss_cnt !== 32'd2) begin
      n_err++; $display("FAIL post_rst_stats got acc=%0d miss=%0d exp 2/2", acc_cnt, miss_cnt); end
    force dut.acc_q = 32'hFFFF_FFFF;
    #1 release dut.acc_q;
    access(32'h440, 1'b0, 32'h0);
    @(negedge clk);
    n_cmp++; if (acc_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL acc_saturate got %h exp ffffffff", acc_cnt); end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    mem[32'h40]   = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    mem[32'h440]  = 256'hB0B00007_B0B00006_B0B00005_B0B00004_B0B00003_B0B00002_B0B00001_B0B00000;
    mem[32'h840]  = 256'hC0C00007_C0C00006_C0C00005_C0C00004_C0C00003_C0C00002_C0C00001_C0C00000;
    mem[32'h1040] = 256'hD0D00007_D0D00006_D0D00005_D0D00004_D0D00003_D0D00002_D0D00001_D0D00000;
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_second_way();
    test_dirty_evict();
    test_ack_ignored();
    test_reset_mid_refill();
`ifdef DCACHE_STATS_EN
    test_stats_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
